melody_sequencer: RTL and testbench

//  Autonomous note source upstream of pwm_audio: steps through a fixed 16-entry melody table and

---
 rtl/melody_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_melody_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Demo note source for pwm_audio: steps a fixed 16-entry melody, driving half-period N and a gate.
// Latency: start registers into LOAD next edge, N/gate change one edge later; no backpressure, stop wins.
module melody_sequencer #(
    parameter int TICK_DIV   = 12000,
    parameter int BEAT_TICKS = 250,
    parameter int GAP_TICKS  = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop_en,
    output logic [9:0] N,
    output logic       gate,
    output logic       busy,
    output logic [3:0] step_idx,
    output logic       done
);

    localparam int             PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [10:0]    BEAT_T    = 11'(BEAT_TICKS);
    localparam logic [10:0]    GAP_T     = 11'(GAP_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        GAP,
        ADV,
        END_CHK
    } state_t;

    // Entry layout {note[2:0], len[2:0]}; len==0 marks the end of the melody.
    function automatic logic [5:0] melody(input logic [3:0] idx);
        logic [5:0] e;
        case (idx)
            4'd0:    e = {3'd1, 3'd1};
            4'd1:    e = {3'd2, 3'd1};
            4'd2:    e = {3'd3, 3'd1};
            4'd3:    e = {3'd4, 3'd2};
            4'd4:    e = {3'd0, 3'd1};
            4'd5:    e = {3'd4, 3'd1};
            4'd6:    e = {3'd3, 3'd1};
            4'd7:    e = {3'd2, 3'd1};
            4'd8:    e = {3'd1, 3'd2};
            default: e = 6'd0;
        endcase
        return e;
    endfunction

    function automatic logic [9:0] period(input logic [2:0] note);
        logic [9:0] p;
        case (note)
            3'd1:    p = 10'd665;
            3'd2:    p = 10'd593;
            3'd3:    p = 10'd498;
            3'd4:    p = 10'd444;
            default: p = 10'd0;
        endcase
        return p;
    endfunction

    state_t        state;
    state_t        state_nxt;
    logic [3:0]    step_nxt;
    logic          load_note;
    logic          done_nxt;
    logic          gate_nxt;
    logic          tick;
    logic          counting;
    logic [PW-1:0] presc;
    logic [10:0]   tick_cnt;
    logic [10:0]   note_ticks;
    logic [10:0]   play_last;
    logic [10:0]   gap_last;
    logic          sounding;
    logic [5:0]    entry;
    logic [2:0]    entry_note;
    logic [2:0]    entry_len;
    logic          entry_sound;

    assign entry       = melody(step_idx);
    assign entry_note  = entry[5:3];
    assign entry_len   = entry[2:0];
    assign entry_sound = (entry_note >= 3'd1) && (entry_note <= 3'd4);

    assign counting  = (state == PLAY) || (state == GAP);
    assign tick      = counting && (presc == PRESC_MAX);
    // Tick indices at which PLAY and GAP end; tick_cnt counts completed ticks from 0.
    assign play_last = note_ticks - GAP_T - 11'd1;
    assign gap_last  = note_ticks - 11'd1;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        step_nxt  = step_idx;
        load_note = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    step_nxt  = 4'd0;
                end
            end
            LOAD: begin
                if (entry_len == 3'd0) begin
                    state_nxt = END_CHK;
                end else begin
                    state_nxt = PLAY;
                    load_note = 1'b1;
                end
            end
            PLAY: begin
                if (tick && (tick_cnt == play_last))
                    state_nxt = GAP;
            end
            GAP: begin
                if (tick && (tick_cnt == gap_last))
                    state_nxt = ADV;
            end
            ADV: begin
                if (step_idx == 4'd15) begin
                    state_nxt = END_CHK;
                end else begin
                    state_nxt = LOAD;
                    step_nxt  = step_idx + 4'd1;
                end
            end
            END_CHK: begin
                step_nxt = 4'd0;
                if (loop_en) begin
                    state_nxt = LOAD;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                step_nxt  = 4'd0;
            end
        endcase

        if (stop) begin
            state_nxt = IDLE;
            step_nxt  = 4'd0;
            load_note = 1'b0;
            done_nxt  = 1'b0;
        end

        gate_nxt = (state_nxt == PLAY) && (load_note ? entry_sound : sounding);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            step_idx <= 4'd0;
            gate     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            step_idx <= step_nxt;
            gate     <= gate_nxt;
            done     <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            tick_cnt <= 11'd0;
        end else if (!counting) begin
            presc    <= '0;
            tick_cnt <= 11'd0;
        end else begin
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
            if (tick)
                tick_cnt <= tick_cnt + 11'd1;
        end
    end

    // A rest keeps the previous N so pwm_audio sees no spurious period change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            N          <= 10'd0;
            note_ticks <= 11'd0;
            sounding   <= 1'b0;
        end else if (load_note) begin
            note_ticks <= 11'(entry_len) * BEAT_T;
            sounding   <= entry_sound;
            if (entry_sound)
                N <= period(entry_note);
        end
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4, BEAT_TICKS=10, GAP_TICKS=2 (one beat = 40 cycles).
module tb_melody_sequencer;

    localparam int TD = 4;
    localparam int BT = 10;
    localparam int GT = 2;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start   = 1'b0;
    logic       stop    = 1'b0;
    logic       loop_en = 1'b0;
    logic [9:0] n_out;
    logic       gate;
    logic       busy;
    logic [3:0] step_idx;
    logic       done;

    int vectors     = 0;
    int miscompares = 0;
    int done_seen   = 0;

    typedef struct {
        int len;
        int n;
        int hi;
    } step_t;

    step_t steps[9];

    melody_sequencer #(
        .TICK_DIV  (TD),
        .BEAT_TICKS(BT),
        .GAP_TICKS (GT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .loop_en (loop_en),
        .N       (n_out),
        .gate    (gate),
        .busy    (busy),
        .step_idx(step_idx),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance to the next falling edge and tally done pulses seen there.
    task automatic step_cyc();
        @(negedge clk);
        if (done === 1'b1)
            done_seen++;
    endtask

    // Leaves the bench at the falling edge inside the LOAD cycle of step 0.
    task automatic pulse_start();
        start = 1'b1;
        step_cyc();
        start = 1'b0;
    endtask

    // Starting in a LOAD cycle, walks steps 0..8 against the golden table; ends in LOAD of step 9.
    task automatic play_pass(input bit poke_start, input bit clear_loop);
        for (int i = 0; i < 9; i++) begin
            int window;
            int bad;
            int hi_cnt;
            window = steps[i].len * BT * TD;
            bad    = 0;
            hi_cnt = 0;
            for (int c = 0; c < window; c++) begin
                step_cyc();
                if (c == 0) begin
                    check($sformatf("step%0d_n", i), 32'(n_out), 32'(steps[i].n));
                    check($sformatf("step%0d_idx", i), 32'(step_idx), 32'(i));
                end
                if (gate !== ((c < steps[i].hi) ? 1'b1 : 1'b0))
                    bad++;
                if (gate === 1'b1)
                    hi_cnt++;
                if (poke_start && i == 2 && c == 5)
                    start = 1'b1;
                if (poke_start && i == 2 && c == 6)
                    start = 1'b0;
                if (clear_loop && i == 3 && c == 0)
                    loop_en = 1'b0;
            end
            check($sformatf("step%0d_gate_high", i), 32'(hi_cnt), 32'(steps[i].hi));
            check($sformatf("step%0d_gate_shape", i), 32'(bad), 32'd0);
            check($sformatf("step%0d_n_hold", i), 32'(n_out), 32'(steps[i].n));
            step_cyc();
            check($sformatf("step%0d_adv_gate", i), 32'(gate), 32'd0);
            check($sformatf("step%0d_adv_busy", i), 32'(busy), 32'd1);
            step_cyc();
        end
    endtask

    // From LOAD of the end marker: END_CHK, then IDLE with a single done cycle.
    task automatic end_no_loop();
        check("end_load_idx", 32'(step_idx), 32'd9);
        check("end_load_busy", 32'(busy), 32'd1);
        step_cyc();
        check("end_chk_done", 32'(done), 32'd0);
        step_cyc();
        check("end_done_pulse", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_idx", 32'(step_idx), 32'd0);
        step_cyc();
        check("end_done_low", 32'(done), 32'd0);
    endtask

    initial begin
        int d0;
        int cnt;
        bit found;

        // One beat = BT*TD = 40 cycles; sounding notes are high for (len*10-2)*4 cycles.
        steps[0] = '{1, 665, 32};
        steps[1] = '{1, 593, 32};
        steps[2] = '{1, 498, 32};
        steps[3] = '{2, 444, 72};
        steps[4] = '{1, 444, 0};
        steps[5] = '{1, 444, 32};
        steps[6] = '{1, 498, 32};
        steps[7] = '{1, 593, 32};
        steps[8] = '{2, 665, 72};

        // Reset state
        step_cyc();
        step_cyc();
        check("rst_n", 32'(n_out), 32'd0);
        check("rst_gate", 32'(gate), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(step_idx), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        repeat (5) step_cyc();
        check("idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a note
        pulse_start();
        repeat (10) step_cyc();
        check("midplay_gate", 32'(gate), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_n", 32'(n_out), 32'd0);
        check("async_rst_gate", 32'(gate), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_idx", 32'(step_idx), 32'd0);
        step_cyc();
        rst_n = 1'b1;
        repeat (20) step_cyc();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_gate", 32'(gate), 32'd0);

        // Single pass, no loop
        loop_en = 1'b0;
        d0 = done_seen;
        pulse_start();
        check("load_gate", 32'(gate), 32'd0);
        play_pass(1'b0, 1'b0);
        end_no_loop();
        check("pass_done_count", 32'(done_seen - d0), 32'd1);

        // Single pass with a stray start during step 2
        d0 = done_seen;
        pulse_start();
        play_pass(1'b1, 1'b0);
        end_no_loop();
        check("poke_done_count", 32'(done_seen - d0), 32'd1);

        // Looping: wrap to step 0, then clear loop_en during the second pass
        loop_en = 1'b1;
        d0 = done_seen;
        pulse_start();
        play_pass(1'b0, 1'b0);
        check("loop_load_idx", 32'(step_idx), 32'd9);
        step_cyc();
        check("loop_endchk_done", 32'(done), 32'd0);
        step_cyc();
        check("loop_wrap_idx", 32'(step_idx), 32'd0);
        check("loop_wrap_busy", 32'(busy), 32'd1);
        check("loop_wrap_nodone", 32'(done_seen - d0), 32'd0);
        play_pass(1'b0, 1'b1);
        end_no_loop();
        check("loop_done_count", 32'(done_seen - d0), 32'd1);

        // stop during step 2 PLAY
        pulse_start();
        found = 1'b0;
        for (int k = 0; k < 500 && !found; k++) begin
            step_cyc();
            if (step_idx == 4'd2 && gate === 1'b1)
                found = 1'b1;
        end
        check("stop_reach_step2", 32'(found), 32'd1);
        repeat (3) step_cyc();
        d0 = done_seen;
        stop = 1'b1;
        step_cyc();
        stop = 1'b0;
        check("stop_gate", 32'(gate), 32'd0);
        check("stop_busy", 32'(busy), 32'd0);
        check("stop_n_hold", 32'(n_out), 32'd498);
        check("stop_idx", 32'(step_idx), 32'd0);
        repeat (10) step_cyc();
        check("stop_busy_later", 32'(busy), 32'd0);
        check("stop_no_done", 32'(done_seen - d0), 32'd0);

        // start and stop together from IDLE
        start = 1'b1;
        stop  = 1'b1;
        step_cyc();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", 32'(busy), 32'd0);
        repeat (5) step_cyc();
        check("startstop_busy_later", 32'(busy), 32'd0);
        check("startstop_gate", 32'(gate), 32'd0);

        // Full-pass length from the start-sampling edge to the done cycle:
        // 9 notes of (len*40+2) with 11 beats total = 458, plus LOAD of the end marker and END_CHK = 460.
        pulse_start();
        cnt = 0;
        while (done !== 1'b1 && cnt < 2000) begin
            step_cyc();
            cnt++;
        end
        check("full_pass_cycles", 32'(cnt), 32'd460);
        check("full_pass_last_n", 32'(n_out), 32'd665);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
